risk_site_scheduler: RTL and testbench

Round-robin scheduler that shares one fuzzy risk engine among four sensor sites. Each site presents a rainfall/soil-moisture pair with a level request. The scheduler grants one site at a time, clamps and forwards its pair to the engine, and pulses the engine enable. It then captures the engine's risk after a fixed latency, reports the result tagged with its site, and maintains a sticky per-site alarm.

---
 rtl/risk_site_scheduler.sv | 131 +++++++++++++
 tb/tb_risk_site_scheduler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/risk_site_scheduler.sv
// Round-robin arbiter sharing one fuzzy risk engine among four sensor sites.
// It clamps the granted site's pair, launches the engine, captures the tagged result and keeps sticky alarms.
module risk_site_scheduler #(
    parameter int unsigned ENG_LAT = 2,
    parameter logic [7:0]  THRESH  = 8'd170
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [31:0] rain_in,
    input  logic [31:0] soil_in,
    output logic [3:0]  ack,
    output logic [7:0]  eng_rain,
    output logic [7:0]  eng_soil,
    output logic        eng_ef,
    input  logic [7:0]  eng_risk,
    output logic [7:0]  risk_out,
    output logic [1:0]  risk_site,
    output logic        risk_valid,
    output logic [3:0]  alarm,
    input  logic [3:0]  alarm_clr,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

    localparam logic [3:0] LAT_M2 = (ENG_LAT > 1) ? 4'(ENG_LAT - 2) : 4'd0;

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_ptr;
    logic [1:0]  r_grant;
    logic [3:0]  r_cnt;
    logic [7:0]  r_eng_rain;
    logic [7:0]  r_eng_soil;
    logic [7:0]  r_risk_out;
    logic [1:0]  r_risk_site;
    logic        r_risk_valid;
    logic [3:0]  r_alarm;

    logic [7:0]  w_rain_clamp [4];
    logic [7:0]  w_soil_clamp [4];
    logic [1:0]  w_idx [4];
    logic [3:0]  w_rot;
    logic [1:0]  w_off;
    logic [1:0]  w_pick;
    logic        w_bypass;
    logic [7:0]  w_risk;
    logic [3:0]  w_set;

    // Per-site clamp, plus request vector rotated so bit 0 is the current pointer.
    for (genvar gi = 0; gi < 4; gi++) begin : g_site
        assign w_rain_clamp[gi] = (rain_in[8*gi +: 8] > 8'd100) ? 8'd100 : rain_in[8*gi +: 8];
        assign w_soil_clamp[gi] = (soil_in[8*gi +: 8] > 8'd100) ? 8'd100 : soil_in[8*gi +: 8];
        assign w_idx[gi]        = r_ptr + 2'(gi);
        assign w_rot[gi]        = req[w_idx[gi]];
    end

    always_comb begin
        w_off = 2'd0;
        if (w_rot[0])      w_off = 2'd0;
        else if (w_rot[1]) w_off = 2'd1;
        else if (w_rot[2]) w_off = 2'd2;
        else if (w_rot[3]) w_off = 2'd3;
    end

    assign w_pick   = r_ptr + w_off;
    // A zero input means the engine is skipped and the result is forced to zero.
    assign w_bypass = (r_eng_rain == 8'd0) || (r_eng_soil == 8'd0);
    assign w_risk   = w_bypass ? 8'd0 : eng_risk;
    assign w_set    = ((r_state == CAPTURE) && (w_risk >= THRESH)) ? (4'b0001 << r_grant) : 4'b0000;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (|req) w_state_next = ISSUE;
            ISSUE:   if (w_bypass || (ENG_LAT == 1)) w_state_next = CAPTURE;
                     else w_state_next = WAIT;
            WAIT:    if (r_cnt == LAT_M2) w_state_next = CAPTURE;
            CAPTURE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_ptr        <= 2'd0;
            r_grant      <= 2'd0;
            r_cnt        <= 4'd0;
            r_eng_rain   <= 8'd0;
            r_eng_soil   <= 8'd0;
            r_risk_out   <= 8'd0;
            r_risk_site  <= 2'd0;
            r_risk_valid <= 1'b0;
            r_alarm      <= 4'd0;
        end else begin
            r_state      <= w_state_next;
            r_risk_valid <= (r_state == CAPTURE);
            r_alarm      <= (r_alarm & ~alarm_clr) | w_set;
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_grant    <= w_pick;
                        r_eng_rain <= w_rain_clamp[w_pick];
                        r_eng_soil <= w_soil_clamp[w_pick];
                    end
                end
                ISSUE:   r_cnt <= 4'd0;
                WAIT:    r_cnt <= r_cnt + 4'd1;
                CAPTURE: begin
                    r_risk_out  <= w_risk;
                    r_risk_site <= r_grant;
                    r_ptr       <= r_grant + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign ack        = (r_state == ISSUE) ? (4'b0001 << r_grant) : 4'b0000;
    assign eng_ef     = (r_state == ISSUE) && !w_bypass;
    assign eng_rain   = r_eng_rain;
    assign eng_soil   = r_eng_soil;
    assign risk_out   = r_risk_out;
    assign risk_site  = r_risk_site;
    assign risk_valid = r_risk_valid;
    assign alarm      = r_alarm;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_risk_site_scheduler.sv
// Directed bench for risk_site_scheduler: an ENG_LAT=2 instance and an ENG_LAT=1 instance,
// each driven by an engine model that returns its value only in the cycle that the engine latency allows.
module tb_risk_site_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req, req1;
    logic [31:0] rain_in, soil_in;
    logic [3:0]  alarm_clr;
    logic [7:0]  eng_val;

    logic [3:0]  ack, ack1;
    logic [7:0]  eng_rain, eng_soil, eng_rain1, eng_soil1;
    logic        eng_ef, eng_ef1;
    logic [7:0]  eng_risk, eng_risk1;
    logic [7:0]  risk_out, risk_out1;
    logic [1:0]  risk_site, risk_site1;
    logic        risk_valid, risk_valid1;
    logic [3:0]  alarm, alarm1;
    logic        busy, busy1;

    logic        ef_d1 = 1'b0, ef_d2 = 1'b0, ef1_d1 = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Engine models: the value is present only in the cycle it is due; 7 appears at any other time.
    always @(posedge clk) begin
        ef_d1  <= eng_ef;
        ef_d2  <= ef_d1;
        ef1_d1 <= eng_ef1;
    end
    assign eng_risk  = ef_d2  ? eng_val : 8'd7;
    assign eng_risk1 = ef1_d1 ? eng_val : 8'd7;

    risk_site_scheduler #(.ENG_LAT(2), .THRESH(8'd170)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .rain_in(rain_in), .soil_in(soil_in),
        .ack(ack), .eng_rain(eng_rain), .eng_soil(eng_soil), .eng_ef(eng_ef),
        .eng_risk(eng_risk), .risk_out(risk_out), .risk_site(risk_site),
        .risk_valid(risk_valid), .alarm(alarm), .alarm_clr(alarm_clr), .busy(busy)
    );

    risk_site_scheduler #(.ENG_LAT(1), .THRESH(8'd170)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .rain_in(rain_in), .soil_in(soil_in),
        .ack(ack1), .eng_rain(eng_rain1), .eng_soil(eng_soil1), .eng_ef(eng_ef1),
        .eng_risk(eng_risk1), .risk_out(risk_out1), .risk_site(risk_site1),
        .risk_valid(risk_valid1), .alarm(alarm1), .alarm_clr(4'b0000), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One request on the ENG_LAT=2 instance; returns cycles from the IDLE grant cycle to risk_valid.
    task automatic txn(input logic [1:0] site, input logic [7:0] rain, input logic [7:0] soil,
                       input logic [7:0] val, input logic exp_ef, input string tag, output int lat);
        rain_in[8*site +: 8] = rain;
        soil_in[8*site +: 8] = soil;
        eng_val = val;
        req = 4'b0001 << site;
        @(negedge clk);
        chk({tag, "_ack"}, 32'(ack), 32'(4'b0001 << site));
        chk({tag, "_ef"},  32'(eng_ef), 32'(exp_ef));
        req = 4'b0000;
        lat = 1;
        while (!risk_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        $display("txn %s site=%0d risk_out=%0d risk_site=%0d latency=%0d alarm=%b",
                 tag, site, risk_out, risk_site, lat, alarm);
    endtask

    logic [3:0] rr_ack_exp  [5] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1};
    logic [1:0] rr_site_exp [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        int lat, ngr, nv, cyc, last;
        rst_n = 1'b0; req = 4'b0; req1 = 4'b0; alarm_clr = 4'b0; eng_val = 8'd0;
        rain_in = 32'd0; soil_in = 32'd0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_ack", 32'(ack), 0);
        chk("rst_ef", 32'(eng_ef), 0);
        chk("rst_rain_soil", {16'd0, eng_rain, eng_soil}, 0);
        chk("rst_risk", {21'd0, risk_out, risk_site, risk_valid}, 0);
        chk("rst_alarm", 32'(alarm), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Round-robin: all four sites, then everyone again after site 3
        for (int s = 0; s < 4; s++) begin
            rain_in[8*s +: 8] = 8'(10 + s);
            soil_in[8*s +: 8] = 8'(20 + s);
        end
        eng_val = 8'd50;
        req = 4'hF;
        ngr = 0; nv = 0; cyc = 0; last = 0;
        while ((ngr < 5 || nv < 5) && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (ack != 4'b0 && ngr < 5) begin
                chk("rr_grant", 32'(ack), 32'(rr_ack_exp[ngr]));
                req = req & ~ack;
                ngr++;
                if (ngr == 4) req = 4'hF;
                else if (ngr == 5) req = 4'h0;
            end
            if (risk_valid && nv < 5) begin
                chk("rr_site", 32'(risk_site), 32'(rr_site_exp[nv]));
                chk("rr_risk", 32'(risk_out), 50);
                if (nv > 0) chk("rr_gap", cyc - last, 4);
                $display("txn rr site=%0d risk_out=%0d cycle=%0d", risk_site, risk_out, cyc);
                last = cyc;
                nv++;
            end
        end
        chk("rr_grants", ngr, 5);
        chk("rr_results", nv, 5);
        chk("rr_alarm", 32'(alarm), 0);

        // Single site, alarm set
        txn(2'd0, 8'd60, 8'd70, 8'd200, 1'b1, "single", lat);
        chk("single_lat", lat, 4);
        chk("single_risk", 32'(risk_out), 200);
        chk("single_site", 32'(risk_site), 0);
        chk("single_alarm", 32'(alarm), 32'h1);
        chk("single_busy", 32'(busy), 0);
        chk("single_rain_held", 32'(eng_rain), 60);
        chk("single_soil_held", 32'(eng_soil), 70);

        // Reset during WAIT discards the in-flight result
        rain_in[7:0] = 8'd20; soil_in[7:0] = 8'd20; eng_val = 8'd250;
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        chk("mid_busy_pre", 32'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_valid", 32'(risk_valid), 0);
        chk("mid_alarm", 32'(alarm), 0);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_rain_soil", {16'd0, eng_rain, eng_soil}, 0);
        chk("mid_risk", {22'd0, risk_out, risk_site}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_valid_after", 32'(risk_valid), 0);
        chk("mid_alarm_after", 32'(alarm), 0);
        rain_in[23:16] = 8'd30; soil_in[23:16] = 8'd30; eng_val = 8'd40;
        req = 4'b1100;
        @(negedge clk);
        chk("mid_regrant", 32'(ack), 32'h4);
        req = 4'b0000;
        lat = 1;
        while (!risk_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("mid_regrant_lat", lat, 4);
        chk("mid_regrant_site", 32'(risk_site), 2);
        $display("txn mid site=%0d risk_out=%0d latency=%0d", risk_site, risk_out, lat);

        // Clamp
        txn(2'd2, 8'd150, 8'd40, 8'd30, 1'b1, "clamp", lat);
        chk("clamp_rain", 32'(eng_rain), 100);
        chk("clamp_soil", 32'(eng_soil), 40);
        chk("clamp_risk", 32'(risk_out), 30);
        chk("clamp_lat", lat, 4);

        // Bypass on zero rainfall
        txn(2'd1, 8'd0, 8'd90, 8'd250, 1'b0, "bypass", lat);
        chk("bypass_lat", lat, 3);
        chk("bypass_risk", 32'(risk_out), 0);
        chk("bypass_site", 32'(risk_site), 1);
        chk("bypass_alarm", 32'(alarm), 0);

        // Alarm set beats a simultaneous clear
        txn(2'd3, 8'd80, 8'd80, 8'd180, 1'b1, "alset", lat);
        chk("alset_alarm", 32'(alarm), 32'h8);
        req = 4'b1000;
        @(negedge clk);
        chk("alclr_ack", 32'(ack), 32'h8);
        req = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        chk("alclr_capture_busy", 32'(busy), 1);
        alarm_clr = 4'b1000;
        @(negedge clk);
        alarm_clr = 4'b0000;
        chk("alclr_valid", 32'(risk_valid), 1);
        chk("alclr_set_wins", 32'(alarm), 32'h8);
        $display("txn alclr site=%0d risk_out=%0d alarm=%b", risk_site, risk_out, alarm);
        alarm_clr = 4'b1000;
        @(negedge clk);
        alarm_clr = 4'b0000;
        chk("alclr_clear", 32'(alarm), 0);

        // ENG_LAT=1 instance
        rain_in[7:0] = 8'd60; soil_in[7:0] = 8'd70; eng_val = 8'd190;
        req1 = 4'b0001;
        @(negedge clk);
        chk("lat1_ack", 32'(ack1), 32'h1);
        chk("lat1_ef", 32'(eng_ef1), 1);
        req1 = 4'b0000;
        @(negedge clk);
        chk("lat1_valid_c2", 32'(risk_valid1), 0);
        chk("lat1_busy_c2", 32'(busy1), 1);
        @(negedge clk);
        chk("lat1_valid_c3", 32'(risk_valid1), 1);
        chk("lat1_risk", 32'(risk_out1), 190);
        chk("lat1_busy_c3", 32'(busy1), 0);
        chk("lat1_alarm", 32'(alarm1), 32'h1);
        $display("txn lat1 site=%0d risk_out=%0d alarm=%b", risk_site1, risk_out1, alarm1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
